// File: rtl/desc_mem_arb_pkg.sv
// Shared types for the descriptor RAM arbiter: width defaults, port ids, command bundle.
// Optional lock support is enabled by defining DESC_MEM_ARB_LOCK_EN.
package desc_mem_arb_pkg;

   localparam int ADDR_W_DEF = 10;
   localparam int DATA_W_DEF = 32;

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_id_e;

   // Command as presented by an Avalon-MM master in one cycle
   typedef struct packed {
      logic [ADDR_W_DEF-1:0]   address;
      logic [DATA_W_DEF/8-1:0] byteenable;
      logic                    read;
      logic                    write;
      logic [DATA_W_DEF-1:0]   writedata;
   } mem_cmd_t;

endpackage

// File: rtl/desc_mem_rr_arb2.sv
// Two-requester round-robin arbiter with registered last_grant.
// With DESC_MEM_ARB_LOCK_EN a granted port asserting lock keeps ownership until it drops lock.
module desc_mem_rr_arb2
   import desc_mem_arb_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
`ifdef DESC_MEM_ARB_LOCK_EN
   input  logic lock_a,
   input  logic lock_b,
`endif
   input  logic req_a,
   input  logic req_b,
   output logic gnt_a,
   output logic gnt_b
);

   port_id_e last_grant;
   logic     rr_a;
   logic     rr_b;

`ifdef DESC_MEM_ARB_LOCK_EN
   logic     lock_vld;
   port_id_e lock_owner;
`endif

   always_comb begin
      rr_a  = req_a && (!req_b || last_grant == PORT_B);
      rr_b  = req_b && !rr_a;
      gnt_a = rr_a;
      gnt_b = rr_b;
`ifdef DESC_MEM_ARB_LOCK_EN
      // An active lock excludes the other port even while the owner is idle
      if (lock_vld) begin
         gnt_a = (lock_owner == PORT_A) && req_a;
         gnt_b = (lock_owner == PORT_B) && req_b;
      end
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant <= PORT_B;
`ifdef DESC_MEM_ARB_LOCK_EN
         lock_vld   <= 1'b0;
         lock_owner <= PORT_A;
`endif
      end else begin
         if (gnt_a)      last_grant <= PORT_A;
         else if (gnt_b) last_grant <= PORT_B;
`ifdef DESC_MEM_ARB_LOCK_EN
         if (gnt_a) begin
            lock_vld   <= lock_a;
            lock_owner <= PORT_A;
         end else if (gnt_b) begin
            lock_vld   <= lock_b;
            lock_owner <= PORT_B;
         end
`endif
      end
   end

endmodule

// File: rtl/desc_mem_arbiter.sv
// Shares the single-port descriptor RAM between the TX (A) and RX (B) SGDMA masters.
// Optional atomic lock inputs are enabled by defining DESC_MEM_ARB_LOCK_EN.
module desc_mem_arbiter
   import desc_mem_arb_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int RD_LATENCY = 1
) (
   input  logic                clk,
   input  logic                reset_n,
`ifdef DESC_MEM_ARB_LOCK_EN
   input  logic                a_lock,
   input  logic                b_lock,
`endif
   input  logic [ADDR_W-1:0]   a_address,
   input  logic [DATA_W/8-1:0] a_byteenable,
   input  logic                a_read,
   input  logic                a_write,
   input  logic [DATA_W-1:0]   a_writedata,
   output logic                a_waitrequest,
   output logic [DATA_W-1:0]   a_readdata,
   output logic                a_readdatavalid,
   input  logic [ADDR_W-1:0]   b_address,
   input  logic [DATA_W/8-1:0] b_byteenable,
   input  logic                b_read,
   input  logic                b_write,
   input  logic [DATA_W-1:0]   b_writedata,
   output logic                b_waitrequest,
   output logic [DATA_W-1:0]   b_readdata,
   output logic                b_readdatavalid,
   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W/8-1:0] mem_byteenable,
   output logic                mem_chipselect,
   output logic                mem_write,
   output logic [DATA_W-1:0]   mem_writedata,
   output logic                mem_clken,
   input  logic [DATA_W-1:0]   mem_readdata
);

   // The response path is a single register stage; the command struct is sized by the package
   if (RD_LATENCY != 1) begin : g_bad_latency
      $error("desc_mem_arbiter: only RD_LATENCY=1 is supported");
   end
   if (ADDR_W != ADDR_W_DEF || DATA_W != DATA_W_DEF) begin : g_bad_width
      $error("desc_mem_arbiter: widths must match desc_mem_arb_pkg defaults");
   end

   mem_cmd_t cmd_a, cmd_b, cmd_g;
   logic     gnt_a, gnt_b;
   logic     rd_pend;
   port_id_e rd_owner;

   assign cmd_a = '{address: a_address, byteenable: a_byteenable, read: a_read,
                    write: a_write, writedata: a_writedata};
   assign cmd_b = '{address: b_address, byteenable: b_byteenable, read: b_read,
                    write: b_write, writedata: b_writedata};

   desc_mem_rr_arb2 u_arb (
      .clk     (clk),
      .reset_n (reset_n),
`ifdef DESC_MEM_ARB_LOCK_EN
      .lock_a  (a_lock),
      .lock_b  (b_lock),
`endif
      .req_a   (a_read | a_write),
      .req_b   (b_read | b_write),
      .gnt_a   (gnt_a),
      .gnt_b   (gnt_b)
   );

   assign cmd_g          = gnt_b ? cmd_b : cmd_a;
   assign mem_address    = cmd_g.address;
   assign mem_byteenable = cmd_g.byteenable;
   assign mem_writedata  = cmd_g.writedata;
   assign mem_chipselect = gnt_a | gnt_b;
   assign mem_write      = mem_chipselect & cmd_g.write;
   assign mem_clken      = 1'b1;

   assign a_waitrequest  = (a_read | a_write) & ~gnt_a;
   assign b_waitrequest  = (b_read | b_write) & ~gnt_b;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_pend  <= 1'b0;
         rd_owner <= PORT_A;
      end else begin
         rd_pend  <= mem_chipselect & cmd_g.read;
         if (mem_chipselect) rd_owner <= gnt_b ? PORT_B : PORT_A;
      end
   end

   assign a_readdatavalid = rd_pend && rd_owner == PORT_A;
   assign b_readdatavalid = rd_pend && rd_owner == PORT_B;
   assign a_readdata      = a_readdatavalid ? mem_readdata : '0;
   assign b_readdata      = b_readdatavalid ? mem_readdata : '0;

endmodule

// File: tb/tb_desc_mem_arbiter.sv
// Table-driven bench for desc_mem_arbiter with a behavioural RAM and a read-response scoreboard.
module tb_desc_mem_arbiter;

   localparam int G_NONE = 0, G_A = 1, G_B = 2;

   typedef struct {
      logic        ar, aw;
      logic [9:0]  aa;
      logic [3:0]  abe;
      logic [31:0] awd;
      logic        br, bw;
      logic [9:0]  ba;
      logic [3:0]  bbe;
      logic [31:0] bwd;
      logic        alk, blk;
      int          gnt;
   } vec_t;

   typedef struct {
      logic        va, vb;
      logic [31:0] data;
   } rsp_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        a_lock, b_lock;
   logic [9:0]  a_address, b_address;
   logic [3:0]  a_byteenable, b_byteenable;
   logic        a_read, a_write, b_read, b_write;
   logic [31:0] a_writedata, b_writedata;
   logic        a_waitrequest, b_waitrequest, a_readdatavalid, b_readdatavalid;
   logic [31:0] a_readdata, b_readdata;
   logic [9:0]  mem_address;
   logic [3:0]  mem_byteenable;
   logic        mem_chipselect, mem_write, mem_clken;
   logic [31:0] mem_writedata, mem_readdata;

   logic [31:0] ram     [0:1023];
   logic [31:0] ref_mem [0:1023];
   rsp_t        rq[$];
   vec_t        tbl[$];
   int          n_pass = 0;
   int          n_tot  = 0;

   always #5 clk = ~clk;

   desc_mem_arbiter dut (
      .clk             (clk),
      .reset_n         (reset_n),
`ifdef DESC_MEM_ARB_LOCK_EN
      .a_lock          (a_lock),
      .b_lock          (b_lock),
`endif
      .a_address       (a_address),
      .a_byteenable    (a_byteenable),
      .a_read          (a_read),
      .a_write         (a_write),
      .a_writedata     (a_writedata),
      .a_waitrequest   (a_waitrequest),
      .a_readdata      (a_readdata),
      .a_readdatavalid (a_readdatavalid),
      .b_address       (b_address),
      .b_byteenable    (b_byteenable),
      .b_read          (b_read),
      .b_write         (b_write),
      .b_writedata     (b_writedata),
      .b_waitrequest   (b_waitrequest),
      .b_readdata      (b_readdata),
      .b_readdatavalid (b_readdatavalid),
      .mem_address     (mem_address),
      .mem_byteenable  (mem_byteenable),
      .mem_chipselect  (mem_chipselect),
      .mem_write       (mem_write),
      .mem_writedata   (mem_writedata),
      .mem_clken       (mem_clken),
      .mem_readdata    (mem_readdata)
   );

   // Single-port RAM, 1-cycle read latency
   always @(posedge clk) begin
      if (mem_clken && mem_chipselect) begin
         if (mem_write) begin
            for (int i = 0; i < 4; i++)
               if (mem_byteenable[i]) ram[mem_address][8*i +: 8] <= mem_writedata[8*i +: 8];
         end else begin
            mem_readdata <= ram[mem_address];
         end
      end
   end

   always @(posedge clk) begin
      assert (!(a_read && a_write) && !(b_read && b_write))
         else $error("FAIL illegal_rw: read and write asserted together");
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   function automatic vec_t mk(input logic ar, aw, input logic [9:0] aa, input logic [3:0] abe,
                               input logic [31:0] awd, input logic br, bw, input logic [9:0] ba,
                               input logic [3:0] bbe, input logic [31:0] bwd,
                               input logic alk, blk, input int g);
      vec_t v;
      v.ar = ar; v.aw = aw; v.aa = aa; v.abe = abe; v.awd = awd;
      v.br = br; v.bw = bw; v.ba = ba; v.bbe = bbe; v.bwd = bwd;
      v.alk = alk; v.blk = blk; v.gnt = g;
      return v;
   endfunction

   task automatic drive(input vec_t t);
      a_read = t.ar; a_write = t.aw; a_address = t.aa; a_byteenable = t.abe; a_writedata = t.awd;
      b_read = t.br; b_write = t.bw; b_address = t.ba; b_byteenable = t.bbe; b_writedata = t.bwd;
      a_lock = t.alk; b_lock = t.blk;
   endtask

   // Drive one cycle, check the combinational command path and last cycle's read response
   task automatic step(input vec_t t);
      rsp_t       e;
      logic       g_rd, g_wr;
      logic [9:0] g_ad;
      logic [3:0] g_be;
      logic [31:0] g_wd, nd;
      drive(t);
      @(negedge clk);
      e = '{va: 1'b0, vb: 1'b0, data: 32'h0};
      if (rq.size() != 0) e = rq.pop_front();
      chk("a_readdatavalid", {31'h0, a_readdatavalid}, {31'h0, e.va});
      chk("b_readdatavalid", {31'h0, b_readdatavalid}, {31'h0, e.vb});
      chk("a_readdata", a_readdata, e.va ? e.data : 32'h0);
      chk("b_readdata", b_readdata, e.vb ? e.data : 32'h0);
      chk("a_waitrequest", {31'h0, a_waitrequest}, {31'h0, (t.ar | t.aw) && t.gnt != G_A});
      chk("b_waitrequest", {31'h0, b_waitrequest}, {31'h0, (t.br | t.bw) && t.gnt != G_B});
      chk("mem_chipselect", {31'h0, mem_chipselect}, {31'h0, t.gnt != G_NONE});
      g_rd = (t.gnt == G_A) ? t.ar  : t.br;
      g_wr = (t.gnt == G_A) ? t.aw  : t.bw;
      g_ad = (t.gnt == G_A) ? t.aa  : t.ba;
      g_be = (t.gnt == G_A) ? t.abe : t.bbe;
      g_wd = (t.gnt == G_A) ? t.awd : t.bwd;
      chk("mem_write", {31'h0, mem_write}, {31'h0, t.gnt != G_NONE && g_wr});
      e = '{va: 1'b0, vb: 1'b0, data: 32'h0};
      if (t.gnt != G_NONE) begin
         chk("mem_address", {22'h0, mem_address}, {22'h0, g_ad});
         if (g_wr) begin
            chk("mem_byteenable", {28'h0, mem_byteenable}, {28'h0, g_be});
            chk("mem_writedata", mem_writedata, g_wd);
            nd = ref_mem[g_ad];
            for (int i = 0; i < 4; i++) if (g_be[i]) nd[8*i +: 8] = g_wd[8*i +: 8];
            ref_mem[g_ad] = nd;
         end else if (g_rd) begin
            e = '{va: t.gnt == G_A, vb: t.gnt == G_B, data: ref_mem[g_ad]};
         end
      end
      rq.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(mk(0,0,10'h0,4'h0,32'h0, 0,0,10'h0,4'h0,32'h0, 0,0, G_NONE));
      reset_n = 1'b0;
      rq.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      drive(mk(0,0,10'h0,4'h0,32'h0, 0,0,10'h0,4'h0,32'h0, 0,0, G_NONE));
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_a_readdatavalid", {31'h0, a_readdatavalid}, 32'h0);
      chk("rst_b_readdatavalid", {31'h0, b_readdatavalid}, 32'h0);
      chk("rst_a_readdata", a_readdata, 32'h0);
      chk("rst_b_readdata", b_readdata, 32'h0);
      chk("rst_waitrequest", {30'h0, a_waitrequest, b_waitrequest}, 32'h0);
      chk("rst_chipselect", {31'h0, mem_chipselect}, 32'h0);
      chk("rst_clken", {31'h0, mem_clken}, 32'h1);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      //         ar aw addr    be    wdata         br bw addr    be    wdata        alk blk gnt
      tbl.push_back(mk(0,1,10'h005,4'hF,32'hDEADBEEF, 0,0,10'h000,4'h0,32'h0,        0,0, G_A));
      tbl.push_back(mk(1,0,10'h005,4'hF,32'h0,        0,0,10'h000,4'h0,32'h0,        0,0, G_A));
      tbl.push_back(mk(0,0,10'h000,4'h0,32'h0,        0,0,10'h000,4'h0,32'h0,        0,0, G_NONE));
      tbl.push_back(mk(0,0,10'h000,4'h0,32'h0,        0,1,10'h3FF,4'hF,32'h3FF3FF00, 0,0, G_B));
      tbl.push_back(mk(0,1,10'h000,4'hF,32'h00012345, 0,0,10'h000,4'h0,32'h0,        0,0, G_A));
      tbl.push_back(mk(0,1,10'h010,4'hF,32'h11223344, 0,0,10'h000,4'h0,32'h0,        0,0, G_A));
      tbl.push_back(mk(0,1,10'h010,4'h2,32'h0000AB00, 0,0,10'h000,4'h0,32'h0,        0,0, G_A));
      tbl.push_back(mk(0,0,10'h000,4'h0,32'h0,        1,0,10'h010,4'hF,32'h0,        0,0, G_B));
      tbl.push_back(mk(1,0,10'h3FF,4'hF,32'h0,        1,0,10'h000,4'hF,32'h0,        0,0, G_A));
      tbl.push_back(mk(1,0,10'h3FF,4'hF,32'h0,        1,0,10'h000,4'hF,32'h0,        0,0, G_B));
      tbl.push_back(mk(1,0,10'h3FF,4'hF,32'h0,        1,0,10'h000,4'hF,32'h0,        0,0, G_A));
      tbl.push_back(mk(1,0,10'h3FF,4'hF,32'h0,        1,0,10'h000,4'hF,32'h0,        0,0, G_B));
      tbl.push_back(mk(1,0,10'h005,4'hF,32'h0,        1,0,10'h010,4'hF,32'h0,        0,0, G_A));
      tbl.push_back(mk(0,1,10'h020,4'hF,32'h55AA55AA, 1,0,10'h010,4'hF,32'h0,        0,0, G_B));
      tbl.push_back(mk(1,0,10'h020,4'hF,32'h0,        0,0,10'h000,4'h0,32'h0,        0,0, G_A));
      tbl.push_back(mk(0,0,10'h000,4'h0,32'h0,        0,0,10'h000,4'h0,32'h0,        0,0, G_NONE));
      foreach (tbl[i]) step(tbl[i]);

      // Reset while a read is in flight: its response must never appear
      step(mk(1,0,10'h005,4'hF,32'h0, 0,0,10'h000,4'h0,32'h0, 0,0, G_A));
      drive(mk(0,0,10'h0,4'h0,32'h0, 0,0,10'h0,4'h0,32'h0, 0,0, G_NONE));
      reset_n = 1'b0;
      #1;
      chk("midrst_a_readdatavalid", {31'h0, a_readdatavalid}, 32'h0);
      chk("midrst_a_readdata", a_readdata, 32'h0);
      chk("midrst_b_readdatavalid", {31'h0, b_readdatavalid}, 32'h0);
      rq.delete();
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      step(mk(1,0,10'h3FF,4'hF,32'h0, 1,0,10'h000,4'hF,32'h0, 0,0, G_A));
      step(mk(0,0,10'h000,4'h0,32'h0, 1,0,10'h000,4'hF,32'h0, 0,0, G_B));
      step(mk(0,0,10'h000,4'h0,32'h0, 0,0,10'h000,4'h0,32'h0, 0,0, G_NONE));

`ifdef DESC_MEM_ARB_LOCK_EN
      do_reset();
      step(mk(1,0,10'h010,4'hF,32'h0,        1,0,10'h005,4'hF,32'h0, 1,0, G_A));
      step(mk(0,0,10'h010,4'h0,32'h0,        1,0,10'h005,4'hF,32'h0, 1,0, G_NONE));
      step(mk(0,1,10'h010,4'hF,32'hCAFEF00D, 1,0,10'h005,4'hF,32'h0, 0,0, G_A));
      step(mk(0,0,10'h000,4'h0,32'h0,        1,0,10'h005,4'hF,32'h0, 0,0, G_B));
      step(mk(1,0,10'h010,4'hF,32'h0,        0,0,10'h000,4'h0,32'h0, 0,0, G_A));
      step(mk(0,0,10'h000,4'h0,32'h0,        0,0,10'h000,4'h0,32'h0, 0,0, G_NONE));
`else
      do_reset();
      step(mk(1,0,10'h010,4'hF,32'h0, 1,0,10'h005,4'hF,32'h0, 1,0, G_A));
      step(mk(1,0,10'h010,4'hF,32'h0, 1,0,10'h005,4'hF,32'h0, 1,0, G_B));
      step(mk(0,0,10'h000,4'h0,32'h0, 0,0,10'h000,4'h0,32'h0, 0,0, G_NONE));
`endif

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/desc_mem_arbiter.md
Name: desc_mem_arbiter

Overview:
- Shares the single-port 1024x32 on-chip descriptor RAM between two Avalon-MM masters: port A (TX SGDMA descriptor fetch/writeback) and port B (RX SGDMA).
- Round-robin arbitration, one RAM access per cycle.
- Read data is returned with fixed 1-cycle latency and routed back to the issuing master via readdatavalid.
- Sits between the two DMA descriptor masters and the RAM's s1 port.

Parameters:
- ADDR_W, 10, word address width (1024 words).
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- RD_LATENCY, 1, RAM read latency in cycles; only value 1 is supported, any other value is an elaboration error.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous active-low reset.
- a_address  in  ADDR_W  port A word address.
- a_byteenable  in  DATA_W/8  port A byte enables.
- a_read / a_write  in  1  port A read/write request; both high together is illegal, and the bench asserts it never occurs.
- a_writedata  in  DATA_W  port A write data.
- a_waitrequest  out  1  port A stall.
- a_readdata  out  DATA_W  port A read data.
- a_readdatavalid  out  1  port A read data valid.
- b_*  same set as port A, for master B.
- mem_address  out  ADDR_W  RAM address.
- mem_byteenable  out  DATA_W/8  RAM byte enables.
- mem_chipselect  out  1  RAM select.
- mem_write  out  1  RAM write.
- mem_writedata  out  DATA_W  RAM write data.
- mem_clken  out  1  RAM clock enable.
- mem_readdata  in  DATA_W  RAM read data, valid 1 cycle after the read is issued.

Behaviour:
- Request: req_x = x_read | x_write.
- Grant is combinational in the same cycle:
  - only A requests -> A;
  - only B requests -> B;
  - both request -> the port not recorded in last_grant.
- last_grant is a register updated on every granted access; reset value B, so A wins the first contention.
- Granted port: waitrequest=0 that cycle and its command drives mem_* directly. Non-granted requesting port: waitrequest=1. Idle port: waitrequest=0.
- mem_chipselect = any grant. mem_write = granted port's write. mem_clken = 1 constant.
- No grant: mem_chipselect=0, mem_write=0, mem_address/byteenable/writedata hold the port A values (don't-care).
- Reads:
  - On a granted read, register rd_pend=1 and rd_owner=port.
  - Next cycle, the owner's readdatavalid=1 and readdata=mem_readdata.
  - readdata stays 0 when readdatavalid=0.
  - Back-to-back reads, including alternating A/B, are fully pipelined: throughput 1/cycle, latency 1.
- Writes: no response. A read issued the cycle after a write to the same address returns the new data (port behaviour is RAM read-during-write DONT_CARE, so the same-cycle case cannot occur because there is a single port).
- Held requests: a master holding its request under waitrequest must keep its address/data stable. The arbiter does not latch commands.
- Reset (async assert): rd_pend=0, rd_owner=A, last_grant=B, all readdatavalid=0, all readdata=0. Waitrequest outputs follow the combinational rules.
- Reset mid-operation: an in-flight read is discarded and no readdatavalid is issued after reset.
- Starvation bound: a continuously requesting port waits at most 1 cycle.

Optional Feature:
- Macro DESC_MEM_ARB_LOCK_EN.
- When defined:
  - Adds inputs a_lock and b_lock (1 bit each).
  - A granted port with lock=1 keeps the grant on subsequent cycles regardless of round-robin, for atomic descriptor status read-modify-write.
  - The lock holder is recorded in a lock_owner register. The lock is released the first cycle after its lock=0 is sampled with the grant.
  - A lock held with no request still blocks the other port (waitrequest=1).
  - Reset clears lock_owner.
- When undefined: ports are absent and arbitration is pure round-robin.

Decomposition:
- Package desc_mem_arb_pkg holds:
  - ADDR_W/DATA_W defaults;
  - a port-id enum (PORT_A, PORT_B);
  - a command struct {address, byteenable, read, write, writedata}.
- Sub-module desc_mem_rr_arb2: 2-requester round-robin grant plus last_grant register (and lock_owner under the macro).
- Top level handles the mux, the read-pending pipeline and response routing.

Test Plan:
- Single A write addr 0x005 data 0xDEADBEEF be 0xF, then A read 0x005 -> a_readdatavalid one cycle after the grant with 0xDEADBEEF, b_readdatavalid=0, no waitrequest.
- A and B both read continuously from cycle 0 -> grants A,B,A,B...; each waitrequest high on alternate cycles; readdatavalid alternates with the correct data.
- Byte write: be=0x2, data 0x0000AB00 over 0x11223344 -> read returns 0x1122AB44.
- Read issued, reset_n pulled low the next cycle -> no readdatavalid, all outputs at reset values, first contention after reset granted to A.
- Address wrap: write 0x3FF and 0x000 with distinct data -> reads return the correct values with no aliasing.
- With DESC_MEM_ARB_LOCK_EN: A read+lock at 0x010, B requesting -> B waitrequest held high until A writes 0x010 with lock=0; B is granted the following cycle.
